// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage: maps MIPS opcode/funct to the ALU operation and holds operands in an ID/EX register.
// Optional operand forwarding from EX/MEM and MEM/WB is compiled in with `define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
   parameter int ANCHO_BUS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic [4:0]           rs_addr,
   input  logic [4:0]           rt_addr,
   input  logic [4:0]           rd_addr,
   input  logic [ANCHO_BUS-1:0] rs_data,
   input  logic [ANCHO_BUS-1:0] rt_data,
   input  logic [15:0]          imm16,
   input  logic                 flush,
   input  logic                 exmem_wr,
   input  logic                 memwb_wr,
   input  logic [4:0]           exmem_addr,
   input  logic [4:0]           memwb_addr,
   input  logic [ANCHO_BUS-1:0] exmem_result,
   input  logic [ANCHO_BUS-1:0] memwb_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           operation,
   output logic [ANCHO_BUS-1:0] data1,
   output logic [ANCHO_BUS-1:0] data2,
   output logic                 reg_write,
   output logic [4:0]           wb_addr,
   output logic                 illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_ILL = 4'b1111;

   logic [3:0]           dec_op;
   logic                 dec_ill;
   logic                 dec_wr;
   logic                 dec_use_imm;
   logic                 dec_sext;
   logic [4:0]           dec_dst;
   logic [ANCHO_BUS-1:0] imm_ext;
   logic [ANCHO_BUS-1:0] rs_fwd;
   logic [ANCHO_BUS-1:0] rt_fwd;
   logic [ANCHO_BUS-1:0] src2;
   logic                 capture;

   always_comb begin
      dec_op      = OP_ILL;
      dec_ill     = 1'b1;
      dec_wr      = 1'b0;
      dec_use_imm = 1'b0;
      dec_sext    = 1'b1;
      dec_dst     = rt_addr;
      case (opcode)
         6'h00: begin
            dec_dst = rd_addr;
            dec_ill = 1'b0;
            dec_wr  = 1'b1;
            case (funct)
               6'h20:   dec_op = OP_ADD;
               6'h22:   dec_op = OP_SUB;
               6'h24:   dec_op = OP_AND;
               6'h25:   dec_op = OP_OR;
               6'h26:   dec_op = OP_XOR;
               6'h2A:   dec_op = OP_SLT;
               default: begin
                  dec_ill = 1'b1;
                  dec_wr  = 1'b0;
               end
            endcase
         end
         6'h08: begin dec_op = OP_ADD; dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; end
         6'h0A: begin dec_op = OP_SLT; dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; end
         6'h0C: begin dec_op = OP_AND; dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; dec_sext = 1'b0; end
         6'h0D: begin dec_op = OP_OR;  dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; dec_sext = 1'b0; end
         6'h0E: begin dec_op = OP_XOR; dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; dec_sext = 1'b0; end
         6'h23: begin dec_op = OP_ADD; dec_ill = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1; end
         6'h2B: begin dec_op = OP_ADD; dec_ill = 1'b0; dec_use_imm = 1'b1; end
         6'h04: begin dec_op = OP_SUB; dec_ill = 1'b0; end
         default: ;
      endcase
   end

   assign imm_ext = dec_sext ? {{(ANCHO_BUS-16){imm16[15]}}, imm16}
                             : {{(ANCHO_BUS-16){1'b0}}, imm16};

`ifdef ALU_ISSUE_FWD_EN
   // A nonzero address match implies the source is nonzero, so r0 is never forwarded.
   assign rs_fwd = (exmem_wr && exmem_addr != 5'd0 && exmem_addr == rs_addr) ? exmem_result :
                   (memwb_wr && memwb_addr != 5'd0 && memwb_addr == rs_addr) ? memwb_result :
                   rs_data;
   assign rt_fwd = (exmem_wr && exmem_addr != 5'd0 && exmem_addr == rt_addr) ? exmem_result :
                   (memwb_wr && memwb_addr != 5'd0 && memwb_addr == rt_addr) ? memwb_result :
                   rt_data;
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_wr, memwb_wr, exmem_addr, memwb_addr, exmem_result, memwb_result};
   assign rs_fwd = rs_data;
   assign rt_fwd = rt_data;
`endif

   assign src2 = dec_use_imm ? imm_ext : rt_fwd;

   // Handshake: a transfer happens on any rising edge where valid and ready are both high;
   // out_valid and payload hold while out_ready is low; in_ready never depends on in_valid.
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         operation <= 4'b0000;
         data1     <= '0;
         data2     <= '0;
         reg_write <= 1'b0;
         wb_addr   <= 5'd0;
         illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         operation <= dec_op;
         data1     <= rs_fwd;
         data2     <= src2;
         reg_write <= dec_wr && (dec_dst != 5'd0);
         wb_addr   <= dec_dst;
         illegal   <= dec_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a scoreboard of issued ALU payloads.
module tb_alu_issue_stage;

   localparam int W  = 32;
   localparam int EW = 4 + W + W + 1 + 5 + 1;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [5:0]   opcode;
   logic [5:0]   funct;
   logic [4:0]   rs_addr, rt_addr, rd_addr;
   logic [W-1:0] rs_data, rt_data;
   logic [15:0]  imm16;
   logic         flush;
   logic         exmem_wr, memwb_wr;
   logic [4:0]   exmem_addr, memwb_addr;
   logic [W-1:0] exmem_result, memwb_result;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   operation;
   logic [W-1:0] data1, data2;
   logic         reg_write;
   logic [4:0]   wb_addr;
   logic         illegal;

   logic         or_drv;
   logic         rand_bp;
   logic         bp_rand;
   int           checks;
   int           errors;
   logic [EW-1:0] exp_q[$];

   assign out_ready = rand_bp ? bp_rand : or_drv;

   alu_issue_stage #(.ANCHO_BUS(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .flush(flush),
      .exmem_wr(exmem_wr), .memwb_wr(memwb_wr), .exmem_addr(exmem_addr), .memwb_addr(memwb_addr),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
      .data1(data1), .data2(data2), .reg_write(reg_write), .wb_addr(wb_addr), .illegal(illegal)
   );

   // clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change at posedge+1, random backpressure at posedge+2, monitor samples at negedge.
   always @(posedge clk) begin
      #2;
      bp_rand <= 1'($urandom_range(0, 1));
   end

   // Reference decode written from the instruction table.
   function automatic logic [EW-1:0] model_now();
      logic [3:0]   o;
      logic         w, il;
      logic [W-1:0] d2, se, ze;
      logic [4:0]   a;
      se = {{16{imm16[15]}}, imm16};
      ze = {16'h0000, imm16};
      o = 4'hF; il = 1'b1; w = 1'b0; d2 = rt_data; a = rt_addr;
      case (opcode)
         6'h00: begin
            a = rd_addr;
            case (funct)
               6'h20: begin o = 4'b0010; il = 1'b0; w = 1'b1; end
               6'h22: begin o = 4'b0110; il = 1'b0; w = 1'b1; end
               6'h24: begin o = 4'b0000; il = 1'b0; w = 1'b1; end
               6'h25: begin o = 4'b0001; il = 1'b0; w = 1'b1; end
               6'h26: begin o = 4'b1001; il = 1'b0; w = 1'b1; end
               6'h2A: begin o = 4'b0111; il = 1'b0; w = 1'b1; end
               default: ;
            endcase
         end
         6'h08: begin o = 4'b0010; il = 1'b0; w = 1'b1; d2 = se; end
         6'h0A: begin o = 4'b0111; il = 1'b0; w = 1'b1; d2 = se; end
         6'h0C: begin o = 4'b0000; il = 1'b0; w = 1'b1; d2 = ze; end
         6'h0D: begin o = 4'b0001; il = 1'b0; w = 1'b1; d2 = ze; end
         6'h0E: begin o = 4'b1001; il = 1'b0; w = 1'b1; d2 = ze; end
         6'h23: begin o = 4'b0010; il = 1'b0; w = 1'b1; d2 = se; end
         6'h2B: begin o = 4'b0010; il = 1'b0; w = 1'b0; d2 = se; end
         6'h04: begin o = 4'b0110; il = 1'b0; w = 1'b0; end
         default: ;
      endcase
      if (a == 5'd0) w = 1'b0;
      return {o, rs_data, d2, w, a, il};
   endfunction

   // driver tasks (entered and left at posedge+1)
   task automatic set_inputs(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input logic [W-1:0] rsd,
                             input logic [W-1:0] rtd, input logic [15:0] imm);
      opcode = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
      rs_data = rsd; rt_data = rtd; imm16 = imm;
   endtask

   task automatic send(input logic [EW-1:0] exp);
      int n;
      in_valid = 1'b1;
      #2;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #3;
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", n);
         @(posedge clk); #1;
      end else begin
         exp_q.push_back(exp);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_random();
      logic [5:0] ops[12];
      logic [5:0] fns[7];
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h3F};
      set_inputs(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 6)],
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom, 16'($urandom));
      send(model_now());
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain pending=%0d out_valid=%b required pending=0 out_valid=0", exp_q.size(), out_valid);
      end
   endtask

   // scoreboard: every accepted issue must match the oldest expectation
   task automatic monitor();
      logic [EW-1:0] e, got;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            checks++;
            got = {operation, data1, data2, reg_write, wb_addr, illegal};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue got %h required none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL issue_payload got %h required %h", got, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      checks++; if (operation !== 4'b0000) begin errors++; $display("FAIL reset_operation got %b required 0000", operation); end
      checks++; if (data1 !== '0)         begin errors++; $display("FAIL reset_data1 got %h required 0", data1); end
      checks++; if (data2 !== '0)         begin errors++; $display("FAIL reset_data2 got %h required 0", data2); end
      checks++; if ({reg_write, wb_addr, illegal} !== 7'd0) begin errors++; $display("FAIL reset_ctrl got %b required 0", {reg_write, wb_addr, illegal}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL idle_in_ready got %b required 1", in_ready); end
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL idle_out_valid got %b required 0", out_valid); end
   endtask

   task automatic test_alu_ops();
      or_drv = 1'b1;
      set_inputs(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0000);
      send(model_now());
      checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL add_valid got %b required 1", out_valid); end
      checks++; if (operation !== 4'b0010) begin errors++; $display("FAIL add_op got %b required 0010", operation); end
      checks++; if (data1 !== 32'd5 || data2 !== 32'd7) begin errors++; $display("FAIL add_data got %h/%h required 5/7", data1, data2); end
      checks++; if (wb_addr !== 5'd3 || reg_write !== 1'b1) begin errors++; $display("FAIL add_wb got %0d/%b required 3/1", wb_addr, reg_write); end
      set_inputs(6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 32'd100, 32'd30, 16'h0000); send(model_now());
      set_inputs(6'h00, 6'h24, 5'd4, 5'd5, 5'd6, 32'hF0F0, 32'h0FF0, 16'h0000); send(model_now());
      set_inputs(6'h00, 6'h25, 5'd4, 5'd5, 5'd7, 32'h1234, 32'h4321, 16'h0000); send(model_now());
      set_inputs(6'h00, 6'h26, 5'd4, 5'd5, 5'd8, 32'hAAAA, 32'h5555, 16'h0000); send(model_now());
      set_inputs(6'h00, 6'h2A, 5'd4, 5'd5, 5'd9, 32'hFFFF_FFFF, 32'd1, 16'h0000); send(model_now());
      set_inputs(6'h04, 6'h00, 5'd4, 5'd5, 5'd9, 32'd8, 32'd8, 16'h0010); send(model_now());
      checks++; if (operation !== 4'b0110 || reg_write !== 1'b0) begin errors++; $display("FAIL beq got op=%b rw=%b required 0110/0", operation, reg_write); end
      set_inputs(6'h23, 6'h00, 5'd2, 5'd11, 5'd0, 32'h1000, 32'h0, 16'hFFFC); send(model_now());
      set_inputs(6'h2B, 6'h00, 5'd2, 5'd11, 5'd0, 32'h1000, 32'h0, 16'h0008); send(model_now());
      checks++; if (reg_write !== 1'b0 || data2 !== 32'd8) begin errors++; $display("FAIL sw got rw=%b d2=%h required 0/8", reg_write, data2); end
      set_inputs(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 16'h0000); send(model_now());
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL r0_dest reg_write got %b required 0", reg_write); end
      wait_drain();
   endtask

   task automatic test_immediates();
      or_drv = 1'b1;
      set_inputs(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 16'hFFFF); send(model_now());
      checks++; if (data2 !== 32'hFFFF_FFFF || operation !== 4'b0010) begin errors++; $display("FAIL addi_sext got %h/%b required ffffffff/0010", data2, operation); end
      set_inputs(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 16'hFFFF); send(model_now());
      checks++; if (data2 !== 32'h0000_FFFF || operation !== 4'b0001) begin errors++; $display("FAIL ori_zext got %h/%b required 0000ffff/0001", data2, operation); end
      set_inputs(6'h0A, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 16'h8000); send(model_now());
      set_inputs(6'h0C, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 16'h8001); send(model_now());
      set_inputs(6'h0E, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd0, 16'hC0DE); send(model_now());
      wait_drain();
   endtask

   task automatic test_stall();
      or_drv = 1'b0;
      set_inputs(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 16'h0000);
      send(model_now());
      set_inputs(6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 32'h99, 32'h11, 16'h0000);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hs cycle %0d got rdy=%b vld=%b required 0/1", i, in_ready, out_valid); end
         checks++; if (operation !== 4'b0010 || data1 !== 32'h10 || data2 !== 32'h20) begin errors++; $display("FAIL stall_payload cycle %0d got %b/%h/%h required 0010/10/20", i, operation, data1, data2); end
         @(posedge clk); #1;
      end
      or_drv = 1'b1;
      exp_q.push_back(model_now());
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || operation !== 4'b0110 || data1 !== 32'h99) begin errors++; $display("FAIL stall_release got %b/%b/%h required 1/0110/99", out_valid, operation, data1); end
      wait_drain();
   endtask

   task automatic test_forwarding();
      logic [W-1:0] e1, e2;
      or_drv = 1'b1;
      exmem_wr = 1'b1; exmem_addr = 5'd4; exmem_result = 32'hAA;
      memwb_wr = 1'b1; memwb_addr = 5'd4; memwb_result = 32'hBB;
      set_inputs(6'h00, 6'h20, 5'd4, 5'd9, 5'd3, 32'h11, 32'h22, 16'h0000);
`ifdef ALU_ISSUE_FWD_EN
      e1 = 32'hAA;
`else
      e1 = 32'h11;
`endif
      send({4'b0010, e1, 32'h22, 1'b1, 5'd3, 1'b0});
      checks++; if (data1 !== e1) begin errors++; $display("FAIL fwd_exmem_wins got %h required %h", data1, e1); end
      exmem_addr = 5'd0; memwb_addr = 5'd9; memwb_result = 32'hCC;
      set_inputs(6'h00, 6'h20, 5'd0, 5'd9, 5'd3, 32'h33, 32'h44, 16'h0000);
`ifdef ALU_ISSUE_FWD_EN
      e2 = 32'hCC;
`else
      e2 = 32'h44;
`endif
      send({4'b0010, 32'h33, e2, 1'b1, 5'd3, 1'b0});
      checks++; if (data1 !== 32'h33 || data2 !== e2) begin errors++; $display("FAIL fwd_r0_memwb got %h/%h required 33/%h", data1, data2, e2); end
      memwb_addr = 5'd4; memwb_result = 32'hBB;
      set_inputs(6'h08, 6'h00, 5'd4, 5'd9, 5'd0, 32'h55, 32'h66, 16'h0001);
`ifdef ALU_ISSUE_FWD_EN
      e1 = 32'hBB;
`else
      e1 = 32'h55;
`endif
      send({4'b0010, e1, 32'h1, 1'b1, 5'd9, 1'b0});
      exmem_wr = 1'b0; memwb_wr = 1'b0;
      exmem_addr = 5'd0; memwb_addr = 5'd0; exmem_result = '0; memwb_result = '0;
      wait_drain();
   endtask

   task automatic test_illegal_flush();
      or_drv = 1'b1;
      set_inputs(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 16'h1234); send(model_now());
      checks++; if (operation !== 4'b1111 || illegal !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL illegal_op got %b/%b/%b required 1111/1/0", operation, illegal, reg_write); end
      checks++; if (data1 !== 32'h77) begin errors++; $display("FAIL illegal_capture got %h required 77", data1); end
      set_inputs(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000); send(model_now());
      wait_drain();
      set_inputs(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000);
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_incoming out_valid got %b required 0", out_valid); end
      or_drv = 1'b0;
      set_inputs(6'h00, 6'h25, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0000); send(model_now());
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held out_valid got %b required 0", out_valid); end
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      or_drv = 1'b1;
      wait_drain();
   endtask

   task automatic test_reset_mid();
      or_drv = 1'b0;
      set_inputs(6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 32'h55, 32'h0, 16'h0003); send(model_now());
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || operation !== 4'b0000 || data1 !== '0 || data2 !== '0 || reg_write !== 1'b0)
         begin errors++; $display("FAIL async_reset got %b/%b/%h/%h/%b required 0/0000/0/0/0", out_valid, operation, data1, data2, reg_write); end
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      or_drv = 1'b1;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      or_drv = 1'b1;
      for (int i = 0; i < 20; i++) send_random();
      rand_bp = 1'b1;
      for (int i = 0; i < 30; i++) send_random();
      rand_bp = 1'b0;
      wait_drain();
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; or_drv = 1'b1; rand_bp = 1'b0;
      set_inputs(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, '0, '0, 16'h0000);
      exmem_wr = 1'b0; memwb_wr = 1'b0; exmem_addr = 5'd0; memwb_addr = 5'd0;
      exmem_result = '0; memwb_result = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_alu_ops();
      test_immediates();
      test_stall();
      test_forwarding();
      test_illegal_flush();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
